// File: rtl/dmux_pkg.sv
// dmux_pkg: shared state encoding and default sizes for the demux dispatch stages
package dmux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SELW  = 3;

endpackage

// File: rtl/dmux_onehot_dec.sv
// dmux_onehot_dec: binary select to one-hot channel vector, all-zero when disabled
//   i_sel    [SELW-1:0]     channel index
//   i_en                    enable; output is all-zero when low
//   o_onehot [2**SELW-1:0]  one-hot channel vector
module dmux_onehot_dec
    import dmux_pkg::*;
#(
    parameter int SELW = DEF_SELW
) (
    input  logic [SELW-1:0]      i_sel,
    input  logic                 i_en,
    output logic [2**SELW-1:0]   o_onehot
);

    localparam logic [2**SELW-1:0] ONE = 1;

    assign o_onehot = i_en ? ONE << i_sel : '0;

endmodule

// File: rtl/dmux_dispatch.sv
// dmux_dispatch: routes one word per handshake to one of 2**SELW channels via a one-entry output register
//   clk, rst              clock and synchronous active-high reset
//   mode                  0 = destination from in_dest, 1 = round-robin pointer
//   in_valid/in_ready     producer handshake; in_ready is combinational from out_ready
//   in_data, in_dest      word and explicit destination, sampled only at load
//   out_valid, out_ready  one-hot channel valid and per-channel consumer ready
//   out_data, out_sel     held word and its binary destination index
//   drop                  one-cycle pulse when a held word times out
// Optional feature macro DMUX_TIMEOUT_EN: discard a word after TIMEOUT+1 offered cycles.
module dmux_dispatch
    import dmux_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SELW    = DEF_SELW,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_dest,
    output logic [2**SELW-1:0]   out_valid,
    input  logic [2**SELW-1:0]   out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 drop
);

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_data;
    logic [SELW-1:0]   r_sel, r_rr;
    logic              w_acc, w_load, w_discard;

    assign w_acc    = out_valid[r_sel] & out_ready[r_sel];
    assign in_ready = (r_state == IDLE) | w_acc;
    assign w_load   = in_valid & in_ready;
    assign out_data = r_data;
    assign out_sel  = r_sel;

    dmux_onehot_dec #(.SELW(SELW)) u_dec (
        .i_sel    (r_sel),
        .i_en     (r_state == HOLD),
        .o_onehot (out_valid)
    );

    // A reload on acceptance keeps HOLD, giving back-to-back streaming without a bubble.
    always_comb begin
        w_next = w_load ? HOLD : (w_acc | w_discard) ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // rr pointer is SELW wide, so the increment wraps modulo 2**SELW by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= '0;
            r_rr   <= '0;
        end else if (w_load) begin
            r_data <= in_data;
            r_sel  <= mode ? r_rr : in_dest;
            if (mode) r_rr <= r_rr + 1'b1;
        end
    end

`ifdef DMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_wait;
    logic          r_drop;

    // Acceptance in the last offered cycle wins because the discard requires no acc.
    assign w_discard = (r_state == HOLD) & ~w_acc & (r_wait == CW'(TIMEOUT));
    assign drop      = r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_discard;
            r_wait <= (w_load | w_discard) ? '0 :
                      (r_state == HOLD && !w_acc) ? r_wait + 1'b1 : r_wait;
        end
    end
`else
    assign w_discard = 1'b0;
    assign drop      = 1'b0;
`endif

endmodule

// File: tb/tb_dmux_dispatch.sv
// tb_dmux_dispatch: directed plus randomized checks of dmux_dispatch against a behavioural model
module tb_dmux_dispatch;

    localparam int WIDTH   = 16;
    localparam int SELW    = 3;
    localparam int NCH     = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst, mode, in_valid, in_ready, drop;
    logic [WIDTH-1:0]  in_data, out_data;
    logic [SELW-1:0]   in_dest, out_sel;
    logic [NCH-1:0]    out_valid, out_ready;

    always #5 clk = ~clk;

    dmux_dispatch #(.WIDTH(WIDTH), .SELW(SELW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .drop      (drop)
    );

    int checks = 0;
    int errors = 0;

    // Model: a held word (or none), its channel, how long it has waited,
    // the round-robin counter, and the last word placed in the output register.
    bit                m_held;
    int                m_sel, m_rr, m_age;
    logic [WIDTH-1:0]  m_data;
    bit                m_drop;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare outputs, then advance the model
    // to what the next rising edge must produce.
    task automatic cyc(input bit r, input bit md, input bit v, input logic [WIDTH-1:0] d,
                       input logic [SELW-1:0] dst, input logic [NCH-1:0] ordy, output bit ld);
        bit          acc, exp_ready;
        logic [7:0]  exp_valid;
        @(negedge clk);
        rst = r; mode = md; in_valid = v; in_data = d; in_dest = dst; out_ready = ordy;
        #1;
        exp_valid = m_held ? 8'(1 << m_sel) : 8'h00;
        acc       = m_held && ordy[m_sel];
        exp_ready = !m_held || acc;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_sel",   32'(out_sel),   32'(m_sel));
        check("out_data",  32'(out_data),  32'(m_data));
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("drop",      32'(drop),      32'(m_drop));
        ld     = !r && v && exp_ready;
        m_drop = 1'b0;
        if (r) begin
            m_held = 0; m_sel = 0; m_rr = 0; m_age = 0; m_data = '0;
        end else if (ld) begin
            m_data = d;
            m_sel  = md ? m_rr : int'(dst);
            if (md) m_rr = (m_rr + 1) % NCH;
            m_held = 1;
            m_age  = 0;
        end else if (acc) begin
            m_held = 0;
        end else if (m_held) begin
`ifdef DMUX_TIMEOUT_EN
            if (m_age == TIMEOUT) begin
                m_held = 0;
                m_drop = 1'b1;
            end else begin
                m_age++;
            end
`else
            m_age++;
`endif
        end
    endtask

    bit               ld;
    bit               pend, pmd;
    logic [WIDTH-1:0] pd;
    logic [SELW-1:0]  pdst;
    int               nvalid, ndrop;

    initial begin
        rst = 1'b1; mode = 0; in_valid = 0; in_data = '0; in_dest = '0; out_ready = '0;
        m_held = 0; m_sel = 0; m_rr = 0; m_age = 0; m_data = '0; m_drop = 0;

        cyc(1, 0, 0, 0, 0, 8'h00, ld);
        cyc(1, 0, 0, 0, 0, 8'h00, ld);
        cyc(0, 0, 0, 0, 0, 8'h00, ld);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);

        // Explicit destination with a blocked consumer, then release.
        cyc(0, 0, 1, 16'hBEEF, 5, 8'h00, ld);
        cyc(0, 0, 0, 0, 0, 8'h00, ld);
        check("beef_valid", 32'(out_valid), 32'h20);
        check("beef_sel", 32'(out_sel), 32'd5);
        check("beef_ready", 32'(in_ready), 32'd0);
        cyc(0, 0, 0, 0, 0, 8'h20, ld);
        cyc(0, 0, 0, 0, 0, 8'h00, ld);
        check("beef_released", 32'(out_valid), 32'd0);

        // Round-robin streaming, one word per cycle.
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, 16'(i), 0, 8'hFF, ld);
            check("stream_accept", 32'(ld), 32'd1);
            if (i > 0) check("stream_sel", 32'(out_sel), 32'((i - 1) % NCH));
        end
        cyc(0, 0, 0, 0, 0, 8'hFF, ld);
        check("stream_last_sel", 32'(out_sel), 32'd1);
        check("stream_last_data", 32'(out_data), 32'd9);

        // Backpressure on channel 2 while every other consumer is ready.
        cyc(0, 0, 1, 16'h1234, 2, 8'hFF, ld);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 16'h5555, 7, 8'hFB, ld);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_data", 32'(out_data), 32'h1234);
        end
        cyc(0, 0, 1, 16'h5555, 7, 8'hFF, ld);
        check("hold_release", 32'(ld), 32'd1);
        cyc(0, 0, 0, 0, 0, 8'hFF, ld);

        // Mixed modes: explicit loads do not advance the round-robin pointer.
        cyc(1, 0, 0, 0, 0, 8'h00, ld);
        cyc(0, 1, 1, 16'hA000, 0, 8'hFF, ld);
        cyc(0, 0, 1, 16'hB000, 6, 8'hFF, ld);
        check("mixed_first", 32'(out_sel), 32'd0);
        cyc(0, 1, 1, 16'hC000, 0, 8'hFF, ld);
        check("mixed_second", 32'(out_sel), 32'd6);
        cyc(0, 0, 0, 0, 0, 8'hFF, ld);
        check("mixed_third", 32'(out_sel), 32'd1);

        // Reset while holding a word.
        cyc(0, 1, 1, 16'hD00D, 0, 8'h00, ld);
        cyc(0, 0, 0, 0, 0, 8'h00, ld);
        cyc(1, 0, 0, 0, 0, 8'h00, ld);
        cyc(0, 1, 1, 16'h0101, 0, 8'h00, ld);
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        check("rst_hold_data", 32'(out_data), 32'd0);
        check("rst_hold_drop", 32'(drop), 32'd0);
        cyc(0, 0, 0, 0, 0, 8'h00, ld);
        check("rst_hold_rr", 32'(out_sel), 32'd0);
        cyc(0, 0, 0, 0, 0, 8'h01, ld);

`ifdef DMUX_TIMEOUT_EN
        // Word offered TIMEOUT+1 cycles, then discarded with a single drop pulse.
        cyc(0, 0, 1, 16'h7777, 3, 8'h00, ld);
        nvalid = 0; ndrop = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0, 0, 0, 8'h00, ld);
            if (out_valid != 0) nvalid++;
            if (drop) ndrop++;
        end
        check("timeout_valid_cycles", 32'(nvalid), 32'(TIMEOUT + 1));
        check("timeout_drops", 32'(ndrop), 32'd1);
        // Acceptance in the final offered cycle wins over the discard.
        cyc(0, 0, 1, 16'h8888, 3, 8'h00, ld);
        for (int i = 0; i < TIMEOUT; i++) cyc(0, 0, 0, 0, 0, 8'h00, ld);
        cyc(0, 0, 0, 0, 0, 8'h08, ld);
        check("timeout_last_valid", 32'(out_valid), 32'h08);
        ndrop = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 8'h00, ld);
            if (drop) ndrop++;
        end
        check("timeout_late_accept_drops", 32'(ndrop), 32'd0);
`endif

        // Randomized traffic with a producer that holds its word until accepted.
        pend = 0; pd = '0; pdst = '0; pmd = 0;
        for (int i = 0; i < 600; i++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1;
                pd   = 16'($urandom);
                pdst = 3'($urandom);
            end
            pmd = 1'($urandom);
            cyc(r, pmd, pend, pd, pdst,
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom | $urandom), ld);
            if (ld || r) pend = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux_dispatch.md
Name: dmux_dispatch

Overview:
- Sequencing controller for the demultiplexer datapath: accepts one Hack-width word per valid/ready handshake and routes it to exactly one of NCH output channels.
- Destination comes either from an explicit select or from an internal round-robin pointer.
- A one-entry output register holds each word until the selected channel accepts it. This gives the demux fabric backpressure and full-throughput streaming.
- Sits between a single producer (CPU/memory-mapped port) and several consumers.

Parameters:
- WIDTH, 16, data word width (Hack word).
- SELW, 3, destination select width.
- NCH, 2**SELW (localparam, derived, not overridable), number of output channels.
- TIMEOUT, 15, cycles a held word may wait before discard (used only with DMUX_TIMEOUT_EN).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit destination (in_dest), 1 = round-robin.
- in_valid  input  1  producer has a word.
- in_ready  output  1  dispatcher accepts this cycle.
- in_data  input  WIDTH  word to route.
- in_dest  input  SELW  destination channel (mode 0 only).
- out_valid  output  NCH  one-hot; bit k = word available on channel k.
- out_ready  input  NCH  per-channel consumer ready.
- out_data  output  WIDTH  held word, shared by all channels.
- out_sel  output  SELW  binary index of the current destination.
- drop  output  1  one-cycle pulse: held word discarded (timeout feature only).

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, out_valid 0, out_data 0, out_sel 0, rr_ptr 0, wait_cnt 0, drop 0. in_ready reads 1 in the cycle after reset releases.
- States:
  - IDLE: nothing held.
  - HOLD: word held in the output register.
- Accept condition: acc = out_valid[out_sel] & out_ready[out_sel] (HOLD only).
- in_ready = (state==IDLE) | acc. This is combinational from out_ready, which is intended for back-to-back streaming.
- Load: on in_valid & in_ready at edge n:
  - out_data <= in_data.
  - out_sel <= (mode ? rr_ptr : in_dest).
  - state <= HOLD.
  - out_valid is visible one-hot from cycle n+1 (latency 1).
- Round-robin: rr_ptr advances by 1 modulo NCH on each load made with mode=1. It does not advance in mode 0. It wraps from NCH-1 to 0. Routing does not skip busy channels.
- mode and in_dest are sampled only at load. A change while in HOLD does not affect the held word.
- HOLD transitions:
  - acc & in_valid: reload the new word, stay in HOLD (no bubble).
  - acc & !in_valid: go to IDLE.
  - !acc: hold out_data/out_sel stable.
- out_ready bits of non-selected channels are ignored. out_valid is never multi-hot.
- in_valid while in HOLD without acc: in_ready is 0. The producer must hold its word.
- Reset mid-HOLD: the held word is lost with no drop pulse, and all reset values apply.

Optional Feature:
- Macro: DMUX_TIMEOUT_EN.
- Defined:
  - wait_cnt (width clog2(TIMEOUT+1)) clears on load.
  - It increments each HOLD cycle without acc.
  - When wait_cnt==TIMEOUT and there is no acc at that edge, the word is discarded: state <= IDLE, out_valid <= 0, drop is high for the next cycle only.
  - A word is therefore offered for TIMEOUT+1 cycles maximum.
  - acc in the final cycle wins over discard.
  - rr_ptr is unaffected by a discard.
- Undefined: no counter. A word is held indefinitely and drop is tied to 0.

Decomposition:
- Package dmux_pkg:
  - state encoding (IDLE=0, HOLD=1).
  - default WIDTH=16 and SELW=3 constants.
- Sub-module dmux_onehot_dec (SELW in, NCH one-hot out, gated by an enable). It builds out_valid from out_sel and (state==HOLD), and is reusable by other demux stages.

Test Plan:
- Reset, then mode=0, in_dest=5, in_data=16'hBEEF, out_ready=0 → next cycle out_valid=8'b0010_0000, out_sel=5, in_ready=0; set out_ready[5]=1 → accepted, state IDLE, out_valid=0.
- mode=1, 10 back-to-back words 0..9, all out_ready=1 → one word per cycle, destinations 0,1,…,7,0,1, no bubbles.
- HOLD on channel 2 with out_ready=8'b1111_1011 → stays held, in_ready=0, out_data stable; raise out_ready[2] → released.
- Mixed modes: mode=1 load (ch0), mode=0 dest 6, mode=1 load → third word goes to ch1, since rr_ptr does not advance in mode 0.
- rst asserted during HOLD → next cycle out_valid=0, out_data=0, rr_ptr=0, drop=0.
- DMUX_TIMEOUT_EN, TIMEOUT=15, out_ready=0 → out_valid high for exactly 16 cycles, then drop=1 for 1 cycle, then IDLE. Repeat with out_ready raised in the 16th cycle → accepted, no drop.
